// File: rtl/song_feeder.sv
// song_feeder: plays a song held in a synchronous ROM. Each ROM word is
// {duration, note word}. Every note word is shown on data_out with
// output_ready, and is held for duration * TICK_DIV enabled clock cycles.
// A zero duration marks the end of the song.
//
// Optional feature: define SONG_FEEDER_LOOP_EN to restart the song from
// address 0 after each end marker or address wrap, until stop is pulsed.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   start        one-cycle pulse; begins playback at address 0 (ignored while busy)
//   stop         one-cycle pulse; aborts playback (beats start)
//   read_en      consumer enable; low pauses playback while a note is held
//   rom_addr     ROM read address
//   rom_data     ROM word, valid one cycle after rom_addr
//   data_out     current note word ([1:0] octave shift, [9:2] note enables)
//   output_ready data_out valid
//   busy         playback in progress
//   done         one-cycle pulse at song end
module song_feeder #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DUR_W    = 6,
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              read_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DUR_W+9:0]  rom_data,
  output logic [9:0]        data_out,
  output logic              output_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StHold, StEnd} state_e;

  state_e           state_q;
  logic [TickW-1:0] tick_q;
  logic [DUR_W-1:0] dur_q;
  logic [9:0]       note_q;
  logic             ready_q;
`ifdef SONG_FEEDER_LOOP_EN
  // Set once a real note has been loaded in the current pass; an empty song
  // must not loop forever.
  logic             played_q;
`endif

  logic [DUR_W-1:0] rom_dur;
  logic             paused;
  logic             note_over;
  logic             finish;

  assign rom_dur   = rom_data[DUR_W+9:10];
  assign paused    = (state_q == StHold) && !read_en;
  assign note_over = (state_q == StHold) && read_en && (tick_q == TickLast) && (dur_q == '0);

  // End of song: an end marker in the ROM, or the last address has finished
  // playing (the address never wraps back to 0 on its own).
  assign finish = ((state_q == StLoad) && (rom_dur == '0)) ||
                  (note_over && (rom_addr == '1));

  // A pause blanks the outputs in the same cycle, and they come back as soon
  // as read_en returns, so the gating is combinational on top of the registers.
  assign data_out     = paused ? '0 : note_q;
  assign output_ready = ready_q && !paused;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      tick_q   <= '0;
      dur_q    <= '0;
      note_q   <= '0;
      ready_q  <= 1'b0;
      rom_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef SONG_FEEDER_LOOP_EN
      played_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (stop && (state_q != StIdle)) begin
        state_q  <= StIdle;
        tick_q   <= '0;
        dur_q    <= '0;
        note_q   <= '0;
        ready_q  <= 1'b0;
        rom_addr <= '0;
        busy     <= 1'b0;
      end else if (finish) begin
        done     <= 1'b1;
        rom_addr <= '0;
        tick_q   <= '0;
        dur_q    <= '0;
`ifdef SONG_FEEDER_LOOP_EN
        if (played_q) begin
          // Restart without dropping busy/output_ready; the old note stays
          // visible through the refetch of entry 0.
          state_q  <= StFetch;
          played_q <= 1'b0;
        end else begin
          state_q <= StEnd;
          busy    <= 1'b0;
          ready_q <= 1'b0;
          note_q  <= '0;
        end
`else
        state_q <= StEnd;
        busy    <= 1'b0;
        ready_q <= 1'b0;
        note_q  <= '0;
`endif
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start && !stop) begin
              state_q  <= StFetch;
              rom_addr <= '0;
              busy     <= 1'b1;
`ifdef SONG_FEEDER_LOOP_EN
              played_q <= 1'b0;
`endif
            end
          end
          // ROM latency: address presented, word arrives next cycle.
          StFetch: state_q <= StLoad;
          StLoad: begin
            // Zero duration was already diverted by finish.
            note_q  <= rom_data[9:0];
            ready_q <= 1'b1;
            dur_q   <= rom_dur - 1'b1;
            tick_q  <= '0;
            state_q <= StHold;
`ifdef SONG_FEEDER_LOOP_EN
            played_q <= 1'b1;
`endif
          end
          StHold: begin
            if (read_en) begin
              if (tick_q == TickLast) begin
                tick_q <= '0;
                if (dur_q == '0) begin
                  // Old note stays on data_out through FETCH/LOAD.
                  rom_addr <= rom_addr + 1'b1;
                  state_q  <= StFetch;
                end else begin
                  dur_q <= dur_q - 1'b1;
                end
              end else begin
                tick_q <= tick_q + 1'b1;
              end
            end
          end
          StEnd:   state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_feeder.sv
// Self-checking bench for song_feeder (ADDR_W=2, DUR_W=6, TICK_DIV=4).
// A behavioural model tracks the song as "cycles of ROM latency left" and
// "enabled cycles of the current note left"; a compare process checks every
// output on every falling edge. Directed scenarios add literal checks.
module tb_song_feeder;
  localparam int unsigned AddrW   = 2;
  localparam int unsigned DurW    = 6;
  localparam int unsigned TickDiv = 4;
`ifdef SONG_FEEDER_LOOP_EN
  localparam bit LoopEn = 1'b1;
`else
  localparam bit LoopEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start, stop, read_en;
  logic [AddrW-1:0] rom_addr;
  logic [DurW+9:0]  rom_data;
  logic [9:0]       data_out;
  logic             output_ready, busy, done;

  logic [DurW+9:0]  rom [4];

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  song_feeder #(
    .ADDR_W  (AddrW),
    .DUR_W   (DurW),
    .TICK_DIV(TickDiv)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .read_en     (read_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .data_out    (data_out),
    .output_ready(output_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit               m_active = 1'b0;
  bit               m_end    = 1'b0;
  bit               m_ready  = 1'b0;
  bit               m_done   = 1'b0;
  bit               m_played = 1'b0;
  int               m_gap    = 0;   // ROM latency cycles before the next word is used
  int               m_left   = 0;   // enabled cycles left for the current note
  logic [AddrW-1:0] m_addr   = '0;
  logic [9:0]       m_note   = '0;

  task automatic m_reset();
    m_active = 1'b0; m_end = 1'b0; m_ready = 1'b0; m_done = 1'b0; m_played = 1'b0;
    m_gap = 0; m_left = 0; m_addr = '0; m_note = '0;
  endtask

  task automatic m_finish();
    m_done = 1'b1;
    m_addr = '0;
    if (LoopEn && m_played) begin
      m_gap    = 2;
      m_played = 1'b0;
    end else begin
      m_active = 1'b0; m_ready = 1'b0; m_note = '0; m_end = 1'b1;
    end
  endtask

  task automatic m_step();
    int dur;
    m_done = 1'b0;
    if (m_end) begin
      m_end = 1'b0;
    end else if (!m_active) begin
      if (start && !stop) begin
        m_active = 1'b1; m_addr = '0; m_gap = 2; m_played = 1'b0;
      end
    end else if (stop) begin
      m_reset();
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) begin
        dur = int'(rom[m_addr][DurW+9:10]);
        if (dur == 0) m_finish();
        else begin
          m_note = rom[m_addr][9:0]; m_ready = 1'b1; m_left = dur * TickDiv; m_played = 1'b1;
        end
      end
    end else if (read_en) begin
      m_left--;
      if (m_left == 0) begin
        if (m_addr == '1) m_finish();
        else begin
          m_addr++; m_gap = 2;
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else     m_step();
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit hold_pause;
    if (check_en) begin
      hold_pause = m_active && (m_gap == 0) && !read_en;
      chk("busy", busy, m_active);
      chk("done", done, m_done);
      chk("rom_addr", rom_addr, m_addr);
      chk("output_ready", output_ready, m_ready && !hold_pause);
      chk("data_out", data_out, hold_pause ? 10'h000 : m_note);
    end
  end

  // ---------------- observation counters ----------------
  int cnt_c, cnt_13, cnt_busy, cnt_done, cnt_nrdy, cnt_idle, wrap_bad;
  bit seen_nz = 1'b0;
  always @(negedge clk) begin
    if (output_ready && data_out == 10'h00C) cnt_c++;
    if (output_ready && data_out == 10'h013) cnt_13++;
    if (busy) cnt_busy++;
    else      cnt_idle++;
    if (done) cnt_done++;
    if (busy && !output_ready) cnt_nrdy++;
    if (!busy) seen_nz = 1'b0;
    else if (rom_addr != '0) seen_nz = 1'b1;
    else if (seen_nz) wrap_bad++;
  end

  task automatic clear_counts();
    cnt_c = 0; cnt_13 = 0; cnt_busy = 0; cnt_done = 0; cnt_nrdy = 0; cnt_idle = 0; wrap_bad = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_default();
    rom[0] = {6'd2, 10'h00C};
    rom[1] = {6'd1, 10'h013};
    rom[2] = '0;
    rom[3] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b1; start = 1'b0; stop = 1'b0; read_en = 1'b1;
    load_default();
    clear_counts();
    #8;
    chk("reset_rom_addr", rom_addr, 0);
    chk("reset_data_out", data_out, 0);
    chk("reset_output_ready", output_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    check_en = 1'b1;
    tick();

`ifndef SONG_FEEDER_LOOP_EN
    // Basic playback: 8 hold + 2 transition cycles of 00C, 4 hold + 2 of 013
    // (the end marker is also fetched/loaded), then one done cycle.
    clear_counts();
    pulse_start();
    ticks(30);
    chk("basic_00C_cycles", cnt_c, 10);
    chk("basic_013_cycles", cnt_13, 6);
    chk("basic_busy_cycles", cnt_busy, 18);
    chk("basic_done_pulses", cnt_done, 1);
    chk("basic_final_data", data_out, 0);
    chk("basic_final_busy", busy, 0);

    // Pause five cycles inside the first note.
    clear_counts();
    pulse_start();
    ticks(4);
    read_en = 1'b0;
    ticks(5);
    read_en = 1'b1;
    ticks(30);
    chk("pause_00C_cycles", cnt_c, 10);
    chk("pause_busy_cycles", cnt_busy, 23);
    chk("pause_notready_cycles", cnt_nrdy, 7);
    chk("pause_done_pulses", cnt_done, 1);
`endif

    // Stop during the second note, with a start in the same cycle.
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (output_ready && data_out == 10'h013) found = 1'b1;
    end
    chk("stop_second_note_seen", found, 1);
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_output_ready", output_ready, 0);
    chk("stop_rom_addr", rom_addr, 0);
    chk("stop_data_out", data_out, 0);
    clear_counts();
    ticks(10);
    chk("stop_no_done", cnt_done, 0);
    chk("stop_start_ignored", cnt_busy, 0);

    // Asynchronous reset between edges in the middle of a note.
    pulse_start();
    ticks(5);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_data_out", data_out, 0);
    chk("arst_output_ready", output_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rom_addr", rom_addr, 0);
    chk("arst_done", done, 0);
    tick();
    rst = 1'b0;
    tick();
    clear_counts();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (output_ready) found = 1'b1;
    end
    chk("arst_replay_ready", found, 1);
    chk("arst_replay_first_note", data_out, 10'h00C);
    ticks(30);

`ifndef SONG_FEEDER_LOOP_EN
    // Address wrap: four one-tick notes and no marker; the last note ends
    // the song without a refetch.
    rom[0] = {6'd1, 10'h101};
    rom[1] = {6'd1, 10'h2A2};
    rom[2] = {6'd1, 10'h303};
    rom[3] = {6'd1, 10'h3F4};
    clear_counts();
    pulse_start();
    ticks(40);
    chk("wrap_busy_cycles", cnt_busy, 24);
    chk("wrap_done_pulses", cnt_done, 1);
    chk("wrap_addr_back_to_0", wrap_bad, 0);
    load_default();
`else
    // Loop: done after the second note, then 00C again, busy throughout.
    load_default();
    clear_counts();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (done) found = 1'b1;
    end
    chk("loop_done_seen", found, 1);
    chk("loop_busy_at_done", busy, 1);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      tick();
      if (output_ready && data_out == 10'h00C) found = 1'b1;
    end
    chk("loop_note_again", found, 1);
    chk("loop_never_idle", cnt_idle, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("loop_stop_busy", busy, 0);
    ticks(3);
`endif

    // Randomised episodes: fresh ROM each time, random start/stop/read_en.
    for (int ep = 0; ep < 8; ep++) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int a = 0; a < 4; a++) rom[a] = {6'($urandom_range(0, 3)), 10'($urandom)};
      for (int c = 0; c < 300; c++) begin
        start   = ($urandom_range(0, 15) == 0);
        stop    = ($urandom_range(0, 79) == 0);
        read_en = ($urandom_range(0, 4) != 0);
        tick();
      end
      start = 1'b0; stop = 1'b0; read_en = 1'b1;
      ticks(2);
    end

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/song_feeder.md
Name: song_feeder

Overview:
- Upstream source for the play-mode stage.
- Walks a song stored in a synchronous ROM; each entry is {duration, note word}.
- Presents each 10-bit note word on data_out with output_ready, and holds it for its duration in ticks.
- Note word format: [1:0] octave shift, [9:2] eight note-enable bits (C..C').
- The play stage asserts read_en while it consumes.

Parameters:
- ADDR_W, 8, ROM address width; song length up to 2^ADDR_W entries.
- DUR_W, 6, duration field width in ticks.
- TICK_DIV, 100000, clk cycles per duration tick; legal range >= 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  one-cycle pulse; begins playback at address 0.
- stop  input  1  one-cycle pulse; aborts playback.
- read_en  input  1  consumer enable; low pauses playback.
- rom_addr  output  ADDR_W  ROM read address.
- rom_data  input  DUR_W+10  ROM word, valid 1 cycle after rom_addr. [DUR_W+9:10] = duration; [9:0] = note word.
- data_out  output  10  current note word.
- output_ready  output  1  data_out valid.
- busy  output  1  playback in progress.
- done  output  1  one-cycle pulse at song end.

Behaviour:
- Reset values: rom_addr=0, data_out=0, output_ready=0, busy=0, done=0, state=IDLE, tick counter=0, duration counter=0.
- IDLE:
  - start=1 and stop=0 -> FETCH, with rom_addr=0 and busy=1.
  - start with stop in the same cycle is ignored; stop wins.
- FETCH: one cycle waiting on ROM latency -> LOAD.
- LOAD, rom_data captured:
  - Duration == 0 (end marker) -> END.
  - Otherwise:
    - data_out <= note word; output_ready <= 1.
    - Duration counter <= duration − 1; tick counter <= 0.
    - -> HOLD.
- HOLD:
  - Tick counter increments each cycle with read_en=1; wraps at TICK_DIV−1.
  - On wrap:
    - Duration counter == 0 -> rom_addr+1, -> FETCH.
    - Otherwise the duration counter decrements.
  - Each note therefore lasts exactly duration×TICK_DIV enabled cycles in HOLD.
- END: done=1 for one cycle; busy, output_ready and data_out cleared -> IDLE.
- Pause (read_en=0 in HOLD):
  - Counters and state are frozen.
  - output_ready is 0 and data_out is forced to 0.
  - Both are restored on the first cycle read_en returns high.
  - FETCH and LOAD proceed regardless of read_en.
- Note-to-note transition:
  - output_ready stays 1 and data_out holds the previous word through FETCH/LOAD.
  - Result: a 2-cycle stretch of the old note, with no zero glitch.
- Address wrap: if rom_addr == 2^ADDR_W−1 and the note completes, treat it as an end marker (-> END). rom_addr never wraps silently.
- stop in any non-IDLE state:
  - Next cycle: IDLE, busy=0, output_ready=0, data_out=0, rom_addr=0.
  - done is not pulsed.
  - stop beats start.
- start while busy: ignored.
- Async rst mid-playback: all outputs take their reset values immediately, independent of clk.

Optional Feature:
- Macro: SONG_FEEDER_LOOP_EN.
- Defined:
  - End marker or address wrap pulses done, then goes directly to FETCH with rom_addr=0.
  - busy and output_ready stay high; playback repeats until stop.
  - A ROM whose entry 0 is an end marker goes to IDLE after the done pulse, with no infinite loop.
- Undefined: END -> IDLE as specified above.

Test Plan:
- Setup for all scenarios: TICK_DIV=4; ROM = {dur 2, 10'h00C}, {dur 1, 10'h013}, {dur 0}.
- Basic playback:
  - Stimulus: start pulse, read_en=1.
  - Required: data_out=10'h00C, output_ready=1 for 8 HOLD cycles + 2 transition cycles; then 10'h013 for 4 cycles; then done pulses once; busy=0; data_out=0.
- Pause:
  - Stimulus: deassert read_en for 5 cycles mid first note.
  - Required: output_ready=0 and data_out=0 during the pause; total enabled HOLD cycles for the first note still 8.
- Stop:
  - Stimulus: stop during the second note.
  - Required: next cycle IDLE, output_ready=0, rom_addr=0, no done pulse; a start on the same cycle as stop is ignored.
- Async reset:
  - Stimulus: assert rst between clock edges mid-HOLD.
  - Required: outputs go to 0 before the next edge; a subsequent start replays from address 0.
- Address wrap:
  - Stimulus: ADDR_W=2, ROM of four notes with dur 1 and no marker.
  - Required: four notes play, then done; rom_addr never returns to 0 while busy.
- Loop (SONG_FEEDER_LOOP_EN defined):
  - Stimulus: default ROM, start.
  - Required: done pulses after the second note, then 10'h00C reappears; busy stays 1 until stop.
